// File: rtl/s2mm_writer.sv
// Stream-to-memory writer: turns each accepted AXI-Stream beat into one single-beat AXI4 write
// at the sync_manager's current buffer address, and reports beats and completions back to it.
module s2mm_writer #(
  parameter int unsigned MM_ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      enable,
  input  logic [DATA_WIDTH-1:0]     S_AXIS_tdata,
  input  logic                      S_AXIS_tvalid,
  output logic                      S_AXIS_tready,
  input  logic [MM_ADDR_WIDTH-1:0]  SM_write_buffer,
  output logic                      SM_reading,
  output logic                      SM_writing,
  output logic [MM_ADDR_WIDTH-1:0]  M_AXI_awaddr,
  output logic [7:0]                M_AXI_awlen,
  output logic [2:0]                M_AXI_awsize,
  output logic [1:0]                M_AXI_awburst,
  output logic                      M_AXI_awvalid,
  input  logic                      M_AXI_awready,
  output logic [DATA_WIDTH-1:0]     M_AXI_wdata,
  output logic [DATA_WIDTH/8-1:0]   M_AXI_wstrb,
  output logic                      M_AXI_wlast,
  output logic                      M_AXI_wvalid,
  input  logic                      M_AXI_wready,
  input  logic [1:0]                M_AXI_bresp,
  input  logic                      M_AXI_bvalid,
  output logic                      M_AXI_bready,
  output logic                      busy,
  output logic [15:0]               error_count
);

  localparam int unsigned         CNT_W    = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [CNT_W-1:0]    MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [2:0]          AXI_SIZE = 3'($clog2(DATA_WIDTH / 8));

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic                       awvalid_q, awvalid_d;
  logic                       wvalid_q, wvalid_d;
  logic [MM_ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;
  logic [CNT_W-1:0]           outstanding_q, outstanding_d;
  logic [15:0]                error_count_q, error_count_d;
  logic                       sm_writing_q, sm_writing_d;
  logic                       bready_q, bready_d;

  logic                       tready;
  logic                       accept;
  logic                       b_take;

  // A beat is only taken when both holding registers can be refilled on the same edge.
  assign tready = (state_q == RUN) && (!awvalid_q || M_AXI_awready) &&
                  (!wvalid_q || M_AXI_wready) && (outstanding_q < MAX_CNT);
  assign accept = S_AXIS_tvalid && tready;
  // Responses with nothing outstanding are spurious and must not disturb any counter.
  assign b_take = M_AXI_bvalid && bready_q && (outstanding_q != '0);

  always_comb begin
    state_d       = state_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    awaddr_d      = awaddr_q;
    wdata_d       = wdata_q;
    outstanding_d = outstanding_q;
    error_count_d = error_count_q;
    sm_writing_d  = b_take;
    bready_d      = 1'b1;

    unique case (state_q)
      IDLE:    if (enable) state_d = RUN;
      RUN:     if (!enable) state_d = DRAIN;
      DRAIN: begin
        if (enable) begin
          state_d = RUN;
        end else if ((outstanding_q == '0) && !awvalid_q && !wvalid_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      awvalid_d = 1'b1;
      awaddr_d  = SM_write_buffer;
    end else if (M_AXI_awready) begin
      awvalid_d = 1'b0;
    end

    if (accept) begin
      wvalid_d = 1'b1;
      wdata_d  = S_AXIS_tdata;
    end else if (M_AXI_wready) begin
      wvalid_d = 1'b0;
    end

    if (accept && !b_take) begin
      outstanding_d = outstanding_q + CNT_W'(1);
    end else if (!accept && b_take) begin
      outstanding_d = outstanding_q - CNT_W'(1);
    end

    if (b_take && (M_AXI_bresp != 2'b00) && (error_count_q != 16'hFFFF)) begin
      error_count_d = error_count_q + 16'd1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= IDLE;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      awaddr_q      <= '0;
      wdata_q       <= '0;
      outstanding_q <= '0;
      error_count_q <= '0;
      sm_writing_q  <= 1'b0;
      bready_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      awaddr_q      <= awaddr_d;
      wdata_q       <= wdata_d;
      outstanding_q <= outstanding_d;
      error_count_q <= error_count_d;
      sm_writing_q  <= sm_writing_d;
      bready_q      <= bready_d;
    end
  end

  assign S_AXIS_tready = tready;
  assign SM_reading    = accept;
  assign SM_writing    = sm_writing_q;
  assign M_AXI_awaddr  = awaddr_q;
  assign M_AXI_awlen   = 8'd0;
  assign M_AXI_awsize  = AXI_SIZE;
  assign M_AXI_awburst = 2'b01;
  assign M_AXI_awvalid = awvalid_q;
  assign M_AXI_wdata   = wdata_q;
  assign M_AXI_wstrb   = '1;
  assign M_AXI_wlast   = 1'b1;
  assign M_AXI_wvalid  = wvalid_q;
  assign M_AXI_bready  = bready_q;
  assign busy          = (state_q != IDLE) || awvalid_q || wvalid_q || (outstanding_q != '0);
  assign error_count   = error_count_q;

endmodule

// File: tb/tb_s2mm_writer.sv
// Directed bench for s2mm_writer: a stream source, sync_manager address model and AXI slave
// feed a scoreboard of expected addresses/data plus a per-cycle model of the SM strobes and errors.
module tb_s2mm_writer;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXO = 8;

  logic            aclk = 1'b0;
  logic            aresetn = 1'b0;
  logic            enable = 1'b0;
  logic [DW-1:0]   s_tdata = '0;
  logic            s_tvalid = 1'b0;
  logic            s_tready;
  logic [AW-1:0]   sm_addr = '0;
  logic            sm_reading;
  logic            sm_writing;
  logic [AW-1:0]   awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic            awvalid;
  logic            awready = 1'b1;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready = 1'b1;
  logic [1:0]      bresp = 2'b00;
  logic            bvalid = 1'b0;
  logic            bready;
  logic            busy;
  logic [15:0]     error_count;

  int checks = 0;
  int failures = 0;

  // stimulus controls owned by the main sequence
  logic            bhold = 1'b0;
  int              b_credit = 0;
  logic            spurious_req = 1'b0;
  logic [AW-1:0]   sm_base = 32'h0000_1000;

  logic [DW-1:0]   src_q[$];
  logic [1:0]      bresp_q[$];
  logic [AW-1:0]   exp_aw_q[$];
  logic [DW-1:0]   exp_w_q[$];

  // bench-side model state
  int              model_out = 0;
  int              accepts = 0;
  int              writes = 0;
  int              aw_done = 0;
  int              w_done = 0;
  int              b_issued = 0;
  logic            exp_wr = 1'b0;
  logic [15:0]     err_model = '0;
  logic            s_acc = 1'b0;
  logic            aw_hs = 1'b0;
  logic            w_hs = 1'b0;
  logic            b_hs = 1'b0;
  logic            sm_rd = 1'b0;
  logic            aw_stall_prev = 1'b0;
  logic            w_stall_prev = 1'b0;
  logic [AW-1:0]   aw_prev_addr = '0;
  logic [DW-1:0]   w_prev_data = '0;
  logic [AW-1:0]   last_awaddr = '0;
  logic [DW-1:0]   last_wdata = '0;

  s2mm_writer #(
    .MM_ADDR_WIDTH   (AW),
    .DATA_WIDTH      (DW),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .enable          (enable),
    .S_AXIS_tdata    (s_tdata),
    .S_AXIS_tvalid   (s_tvalid),
    .S_AXIS_tready   (s_tready),
    .SM_write_buffer (sm_addr),
    .SM_reading      (sm_reading),
    .SM_writing      (sm_writing),
    .M_AXI_awaddr    (awaddr),
    .M_AXI_awlen     (awlen),
    .M_AXI_awsize    (awsize),
    .M_AXI_awburst   (awburst),
    .M_AXI_awvalid   (awvalid),
    .M_AXI_awready   (awready),
    .M_AXI_wdata     (wdata),
    .M_AXI_wstrb     (wstrb),
    .M_AXI_wlast     (wlast),
    .M_AXI_wvalid    (wvalid),
    .M_AXI_wready    (wready),
    .M_AXI_bresp     (bresp),
    .M_AXI_bvalid    (bvalid),
    .M_AXI_bready    (bready),
    .busy            (busy),
    .error_count     (error_count)
  );

  always #5 aclk = ~aclk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [DW-1:0] first, input int n);
    for (int i = 0; i < n; i++) src_q.push_back(first + DW'(i));
  endtask

  task automatic clearAll();
    s_tvalid = 1'b0;
    s_tdata = '0;
    bvalid = 1'b0;
    bresp = 2'b00;
    src_q.delete();
    bresp_q.delete();
    exp_aw_q.delete();
    exp_w_q.delete();
    model_out = 0;
    aw_done = 0;
    w_done = 0;
    b_issued = 0;
    b_credit = 0;
    exp_wr = 1'b0;
    err_model = '0;
    s_acc = 1'b0;
    aw_hs = 1'b0;
    w_hs = 1'b0;
    b_hs = 1'b0;
    sm_rd = 1'b0;
    aw_stall_prev = 1'b0;
    w_stall_prev = 1'b0;
    spurious_req = 1'b0;
    sm_addr = sm_base;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge aclk);
    #2;
  endtask

  task automatic waitQuiet(input string tag, input int budget);
    logic quiet;
    quiet = 1'b0;
    for (int i = 0; i < budget && !quiet; i++) begin
      @(negedge aclk);
      #2;
      quiet = (src_q.size() == 0) && !s_tvalid && (model_out == 0) && !awvalid && !wvalid && !bvalid;
    end
    checkOutput(tag, quiet, 1'b1);
    cycles(2);
  endtask

  // Source, sync_manager model and AXI slave: decide handshakes at negedge+1, drive at posedge+1.
  always begin
    @(negedge aclk);
    #1;
    if (!aresetn) begin
      clearAll();
    end else begin
      checkOutput("sm_writing", sm_writing, exp_wr);
      checkOutput("error_count", error_count, err_model);
      if (aw_stall_prev) begin
        checkOutput("aw_hold_valid", awvalid, 1'b1);
        checkOutput("aw_hold_addr", awaddr, aw_prev_addr);
      end
      if (w_stall_prev) begin
        checkOutput("w_hold_valid", wvalid, 1'b1);
        checkOutput("w_hold_data", wdata, w_prev_data);
      end
      s_acc = s_tvalid && s_tready;
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      b_hs  = bvalid && bready;
      sm_rd = sm_reading;
      checkOutput("sm_reading", sm_reading, s_acc);
      checkOutput("tready_cap", s_tready && (model_out >= MAXO), 1'b0);
      if (s_acc) begin
        exp_aw_q.push_back(sm_addr);
        exp_w_q.push_back(s_tdata);
        accepts++;
      end
      if (aw_hs) begin
        checkOutput("aw_sb_nonempty", exp_aw_q.size() > 0, 1'b1);
        if (exp_aw_q.size() > 0) checkOutput("awaddr", awaddr, exp_aw_q.pop_front());
        aw_done++;
        last_awaddr = awaddr;
      end
      if (w_hs) begin
        checkOutput("w_sb_nonempty", exp_w_q.size() > 0, 1'b1);
        if (exp_w_q.size() > 0) checkOutput("wdata", wdata, exp_w_q.pop_front());
        w_done++;
        last_wdata = wdata;
      end
      exp_wr = b_hs && (model_out > 0);
      if (exp_wr && (bresp != 2'b00) && (err_model != 16'hFFFF)) err_model = err_model + 16'd1;
      model_out = model_out + (s_acc ? 1 : 0) - (exp_wr ? 1 : 0);
      if (sm_writing) writes++;
      aw_stall_prev = awvalid && !awready;
      aw_prev_addr  = awaddr;
      w_stall_prev  = wvalid && !wready;
      w_prev_data   = wdata;
    end
    @(posedge aclk);
    #1;
    if (!aresetn) begin
      clearAll();
    end else begin
      if (sm_rd) sm_addr = sm_addr + 32'd4;
      if (s_acc) s_tvalid = 1'b0;
      if (!s_tvalid && src_q.size() > 0) begin
        s_tdata = src_q.pop_front();
        s_tvalid = 1'b1;
      end
      if (b_hs) bvalid = 1'b0;
      if (spurious_req && !bvalid) begin
        bvalid = 1'b1;
        bresp = 2'b10;
        spurious_req = 1'b0;
      end else if (!bvalid && ((aw_done < w_done ? aw_done : w_done) > b_issued) &&
                   (!bhold || b_credit > 0)) begin
        bvalid = 1'b1;
        bresp = (bresp_q.size() > 0) ? bresp_q.pop_front() : 2'b00;
        b_issued++;
        if (bhold) b_credit--;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int a0;
    int w0;
    logic [1:0] pattern [10];

    // reset state
    cycles(2);
    checkOutput("rst_awvalid", awvalid, 1'b0);
    checkOutput("rst_wvalid", wvalid, 1'b0);
    checkOutput("rst_tready", s_tready, 1'b0);
    checkOutput("rst_sm_reading", sm_reading, 1'b0);
    checkOutput("rst_sm_writing", sm_writing, 1'b0);
    checkOutput("rst_bready", bready, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_error_count", error_count, 16'd0);
    #1 aresetn = 1'b1;

    // 1: four beats straight through at 0x1000..0x100C
    @(negedge aclk);
    enable = 1'b1;
    a0 = accepts;
    w0 = writes;
    applyStimulus(32'hA0, 4);
    waitQuiet("t1_quiet", 60);
    checkOutput("t1_accepts", accepts - a0, 4);
    checkOutput("t1_writes", writes - w0, 4);
    checkOutput("t1_last_awaddr", last_awaddr, 32'h0000_100C);
    checkOutput("t1_last_wdata", last_wdata, 32'hA3);
    checkOutput("t1_bready", bready, 1'b1);
    checkOutput("awlen", awlen, 8'd0);
    checkOutput("awsize", awsize, 3'd2);
    checkOutput("awburst", awburst, 2'b01);
    checkOutput("wstrb", wstrb, 4'hF);
    checkOutput("wlast", wlast, 1'b1);

    // 2: address channel stalled, data channel free
    @(negedge aclk);
    awready = 1'b0;
    a0 = accepts;
    applyStimulus(32'hB0, 3);
    cycles(6);
    checkOutput("t2_accepts_stalled", accepts - a0, 1);
    checkOutput("t2_tready", s_tready, 1'b0);
    checkOutput("t2_awvalid", awvalid, 1'b1);
    checkOutput("t2_wvalid", wvalid, 1'b0);
    @(negedge aclk);
    awready = 1'b1;
    waitQuiet("t2_quiet", 60);
    checkOutput("t2_accepts", accepts - a0, 3);
    checkOutput("t2_last_awaddr", last_awaddr, 32'h0000_1018);

    // 3: responses withheld, outstanding limit
    @(negedge aclk);
    bhold = 1'b1;
    a0 = accepts;
    w0 = writes;
    applyStimulus(32'hC0, 10);
    cycles(14);
    checkOutput("t3_accepts_cap", accepts - a0, 8);
    checkOutput("t3_tready", s_tready, 1'b0);
    @(negedge aclk);
    b_credit = 1;
    cycles(5);
    checkOutput("t3_accepts_after_one_b", accepts - a0, 9);
    checkOutput("t3_writes_after_one_b", writes - w0, 1);
    @(negedge aclk);
    bhold = 1'b0;
    waitQuiet("t3_quiet", 80);
    checkOutput("t3_accepts", accepts - a0, 10);
    checkOutput("t3_writes", writes - w0, 10);

    // 4: three SLVERR responses out of ten
    pattern = '{2'b00, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00};
    @(negedge aclk);
    for (int i = 0; i < 10; i++) bresp_q.push_back(pattern[i]);
    w0 = writes;
    applyStimulus(32'hD0, 10);
    waitQuiet("t4_quiet", 80);
    checkOutput("t4_error_count", error_count, 16'd3);
    checkOutput("t4_writes", writes - w0, 10);

    // spurious response while nothing is outstanding
    @(negedge aclk);
    w0 = writes;
    spurious_req = 1'b1;
    cycles(4);
    checkOutput("spur_error_count", error_count, 16'd3);
    checkOutput("spur_writes", writes - w0, 0);

    // 5: disable with five writes outstanding, then drain
    @(negedge aclk);
    bhold = 1'b1;
    a0 = accepts;
    w0 = writes;
    applyStimulus(32'h50, 5);
    for (int i = 0; i < 30 && (accepts - a0) < 5; i++) cycles(1);
    enable = 1'b0;
    applyStimulus(32'h60, 2);
    cycles(4);
    checkOutput("t5_accepts", accepts - a0, 5);
    checkOutput("t5_tready", s_tready, 1'b0);
    checkOutput("t5_busy_draining", busy, 1'b1);
    @(negedge aclk);
    bhold = 1'b0;
    for (int i = 0; i < 30 && (writes - w0) < 5; i++) cycles(1);
    checkOutput("t5_writes", writes - w0, 5);
    checkOutput("t5_busy_at_last_pulse", busy, 1'b1);
    cycles(1);
    checkOutput("t5_busy_idle", busy, 1'b0);
    checkOutput("t5_sm_writing_end", sm_writing, 1'b0);
    checkOutput("t5_no_new_accepts", accepts - a0, 5);

    // 6: reset in the middle of stalled traffic
    @(negedge aclk);
    awready = 1'b0;
    wready = 1'b0;
    enable = 1'b1;
    applyStimulus(32'h70, 2);
    cycles(4);
    checkOutput("t6_awvalid_pre", awvalid, 1'b1);
    checkOutput("t6_wvalid_pre", wvalid, 1'b1);
    #1;
    sm_base = 32'h0000_2000;
    aresetn = 1'b0;
    #1;
    checkOutput("t6_awvalid_async", awvalid, 1'b0);
    checkOutput("t6_wvalid_async", wvalid, 1'b0);
    checkOutput("t6_tready_async", s_tready, 1'b0);
    checkOutput("t6_busy_async", busy, 1'b0);
    repeat (2) @(negedge aclk);
    awready = 1'b1;
    wready = 1'b1;
    #3 aresetn = 1'b1;
    cycles(2);
    checkOutput("t6_error_count", error_count, 16'd0);
    checkOutput("t6_bready", bready, 1'b1);
    @(negedge aclk);
    a0 = accepts;
    applyStimulus(32'hE0, 1);
    waitQuiet("t6_quiet", 60);
    checkOutput("t6_accepts", accepts - a0, 1);
    checkOutput("t6_first_awaddr", last_awaddr, 32'h0000_2000);
    checkOutput("t6_first_wdata", last_wdata, 32'hE0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
